// File: rtl/packet_pkg.sv
// Shared packet-level types for the switch_4port test infrastructure.
// Holds the packet type encoding, the port count, the traffic-generator
// state type and the destination-mask helper used by switch_traffic_gen.
package packet_pkg;

  localparam int unsigned NUM_PORTS = 4;

  typedef enum logic [1:0] {
    PKT_DATA  = 2'd0,
    PKT_CTRL  = 2'd1,
    PKT_MCAST = 2'd2,
    PKT_RSVD  = 2'd3
  } pkt_type_e;

  typedef enum logic [2:0] {
    TG_IDLE,
    TG_GAP,
    TG_SEND,
    TG_STALL,
    TG_DONE
  } tg_state_e;

  // Destination mask from four random bits: never targets the sending port,
  // never empty. An empty mask falls back to the next port up, wrapping 3->0
  // through the 2-bit add.
  function automatic logic [3:0] tg_target(input logic [3:0] raw,
                                           input logic [1:0] port_id);
    logic [3:0] mask;
    logic [1:0] next_port;
    mask      = raw & ~(4'b0001 << port_id);
    next_port = port_id + 2'd1;
    if (mask == '0) begin
      mask = 4'b0001 << next_port;
    end
    return mask;
  endfunction

endpackage

// File: rtl/tg_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) for the traffic generator.
// Ports:
//   clk_i     clock
//   rst_i     asynchronous active-high reset, loads the seed
//   enable_i  advance one step this cycle
//   value_o   low OUT_W bits of the current register value
// A zero seed would lock the register up, so it is replaced by 16'h0001.
module tg_lfsr16 #(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  output logic [OUT_W-1:0] value_o
);

  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= SEED_NZ;
    end else if (enable_i) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/switch_traffic_gen.sv
// Pseudo-random single-beat packet source for one switch_4port ingress port.
// Backpressured by the ingress FIFO full flag so it never causes a drop.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        pulse: begin a run (honoured only in IDLE or DONE)
//   abort        level: end the run after the current beat
//   fifo_full    ingress FIFO full from switch_port
//   valid_in     beat valid towards the switch
//   source_in    constant PORT_ID
//   target_in    destination mask, never zero, never includes PORT_ID
//   pkt_type     packet type (pkt_type_e)
//   data_in      {seq[5:0], pkt_type}
//   busy, done   run in progress / run finished
//   sent_cnt     beats accepted this run
//   stall_cnt    cycles spent stalled this run, saturating
module switch_traffic_gen
  import packet_pkg::*;
#(
  parameter int unsigned PORT_ID  = 0,
  parameter int unsigned NUM_PKTS = 20,
  parameter int unsigned MAX_GAP  = 7,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        fifo_full,
  output logic        valid_in,
  output logic [1:0]  source_in,
  output logic [3:0]  target_in,
  output logic [1:0]  pkt_type,
  output logic [7:0]  data_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] sent_cnt,
  output logic [15:0] stall_cnt
);

  tg_state_e   state_q;
  logic        send_q;
  logic        busy_q;
  logic        done_q;
  logic [3:0]  gap_q;
  logic [3:0]  target_q;
  pkt_type_e   type_q;
  logic [7:0]  data_q;
  logic [5:0]  seq_q;
  logic [15:0] sent_q;
  logic [15:0] stall_q;

  logic [9:0]  lfsr;
  logic [3:0]  gap_d;
  logic [3:0]  target_d;
  logic        last_pkt;

  tg_lfsr16 #(
    .SEED  (SEED),
    .OUT_W (10)
  ) u_lfsr (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (busy_q),
    .value_o  (lfsr)
  );

  always_comb begin
    gap_d    = 4'({28'd0, lfsr[3:0]} % (MAX_GAP + 1));
    target_d = tg_target(lfsr[7:4], 2'(PORT_ID));
    last_pkt = (sent_q + 16'd1) == 16'(NUM_PKTS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= TG_IDLE;
      send_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gap_q    <= '0;
      target_q <= '0;
      type_q   <= PKT_DATA;
      data_q   <= '0;
      seq_q    <= '0;
      sent_q   <= '0;
      stall_q  <= '0;
    end else begin
      case (state_q)
        TG_IDLE, TG_DONE: begin
          if (start && !abort) begin
            sent_q  <= '0;
            stall_q <= '0;
            seq_q   <= '0;
            gap_q   <= gap_d;
            state_q <= TG_GAP;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        TG_GAP: begin
          if (abort) begin
            state_q <= TG_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (gap_q == '0) begin
            // Fields are frozen here and held through any stall until accepted.
            state_q  <= TG_SEND;
            send_q   <= 1'b1;
            target_q <= target_d;
            type_q   <= pkt_type_e'(lfsr[9:8]);
            data_q   <= {seq_q, lfsr[9:8]};
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        TG_SEND: begin
          send_q <= 1'b0;
          if (fifo_full) begin
            state_q <= TG_STALL;
          end else begin
            sent_q <= sent_q + 16'd1;
            seq_q  <= seq_q + 6'd1;
            if (last_pkt || abort) begin
              state_q <= TG_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              gap_q   <= gap_d;
              state_q <= TG_GAP;
            end
          end
        end
        TG_STALL: begin
          if (stall_q != '1) begin
            stall_q <= stall_q + 16'd1;
          end
          if (abort) begin
            state_q <= TG_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (!fifo_full) begin
            state_q <= TG_SEND;
            send_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= TG_IDLE;
          send_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // The SEND flag is registered; gating it with fifo_full keeps valid_in low
  // whenever the FIFO is full at the sampling edge, so no beat can be dropped.
  assign valid_in  = send_q & ~fifo_full;
  assign source_in = 2'(PORT_ID);
  assign target_in = target_q;
  assign pkt_type  = type_q;
  assign data_in   = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sent_cnt  = sent_q;
  assign stall_cnt = stall_q;

endmodule
